// File: rtl/xs_snd_pkg.sv
// xs_snd_pkg: shared types and default sizing for the sound command queue.
// Exports the scheduler state type and DEPTH/HOLD/DW defaults.
package xs_snd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    READ,
    GAP
  } sndq_state_t;

  localparam int SNDQ_DEPTH = 8;
  localparam int SNDQ_HOLD  = 16;
  localparam int SNDQ_DW    = 8;

endpackage

// File: rtl/xs_sndcmd_queue_if.sv
// xs_sndcmd_queue_if: main-CPU strobe/data, sound-CPU select, queue status.
// master = CPU side (drives strobes), slave = queue (drives cmd/irq/flags).
interface xs_sndcmd_queue_if #(
  parameter int DEPTH = xs_snd_pkg::SNDQ_DEPTH,
  parameter int DW    = xs_snd_pkg::SNDQ_DW
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          W3A08n;
  logic [DW-1:0] DB_in;
  logic          sel_n;
  logic [DW-1:0] cmd_q;
  logic          irq_n;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;

  modport master (
    output W3A08n, DB_in, sel_n,
    input  cmd_q, irq_n, count, full, empty, ovf
  );

  modport slave (
    input  W3A08n, DB_in, sel_n,
    output cmd_q, irq_n, count, full, empty, ovf
  );

endinterface

// File: rtl/xs_sndcmd_ram.sv
// xs_sndcmd_ram: DEPTH x DW register array, sync write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module xs_sndcmd_ram #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xs_sndcmd_queue.sv
// xs_sndcmd_queue: main-to-sound command FIFO with one IRQ per command.
// Ports: clk, RSTn (async low), bus (slave: strobes in, cmd/irq/flags out).
module xs_sndcmd_queue
  import xs_snd_pkg::*;
#(
  parameter int DEPTH = SNDQ_DEPTH,
  parameter int DW    = SNDQ_DW,
  parameter int HOLD  = SNDQ_HOLD
) (
  input logic               clk,
  input logic               RSTn,
  xs_sndcmd_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(HOLD - 1);

  sndq_state_t   state;
  sndq_state_t   state_nx;
  logic          last_w;
  logic          last_sel;
  logic          push_evt;
  logic          rise_sel;
  logic          push_ok;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic [DW-1:0] head;
  logic [DW-1:0] cmd_q;
  logic          irq_n;
  logic          ovf;
  logic          full;
  logic          empty;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_evt = bus.W3A08n & ~last_w;
  assign rise_sel = bus.sel_n & ~last_sel;
  assign push_ok  = push_evt & ~full;
  assign pop      = rise_sel & (state == READ) & ~empty;

  xs_sndcmd_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.DB_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      last_w   <= 1'b1;
      last_sel <= 1'b1;
    end else begin
      last_w   <= bus.W3A08n;
      last_sel <= bus.sel_n;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_evt & full) ovf <= 1'b1;
    end
  end

  // Head is reloaded every cycle so cmd_q tracks pops; while empty
  // it keeps the last byte, like the original latch.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cmd_q <= {DW{1'b1}};
    end else if (!empty) begin
      cmd_q <= head;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!empty)     state_nx = PEND;
      PEND: if (!bus.sel_n) state_nx = READ;
      READ: if (rise_sel)   state_nx = GAP;
      GAP:  if (gap_cnt == '0)
              state_nx = empty ? IDLE : PEND;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      irq_n   <= 1'b1;
      gap_cnt <= GAP_LOAD;
    end else begin
      state <= state_nx;
      irq_n <= (state_nx != PEND);
      // Preloaded outside GAP so the count starts at HOLD-1 on entry.
      if (state != GAP)
        gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign bus.cmd_q = cmd_q;
  assign bus.irq_n = irq_n;
  assign bus.count = count;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf;

endmodule

// File: doc/xs_sndcmd_queue.md
# xs_sndcmd_queue

Main-to-sound CPU command scheduler that replaces the single-byte sound latch with a small FIFO. It sits between the main CPU latch strobe (W3A08n) and the sound CPU decoder select for the latch window (0x1000-0x17FF). It sequences the sound CPU IRQ so that each queued command produces one interrupt. Bursts of commands written by the main CPU within one sound frame are therefore not lost.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, 2..64.
- DW, 8: command width.
- HOLD, 16: number of clk cycles irq_n is held high between consecutive interrupts.

Ports:
- clk  in  1  master clock; every register is clocked on posedge.
- RSTn  in  1  reset; asynchronous assertion, active low.
- W3A08n  in  1  main CPU latch strobe; a push happens on its rising edge.
- DB_in  in  DW  main CPU data; sampled on the same edge as the push.
- sel_n  in  1  sound CPU latch select (decoder Y2, active low); a pop happens on its rising edge.
- cmd_q  out  DW  head command driven to the sound CPU bus mux.
- irq_n  out  1  sound CPU IRQ, active low.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky flag: a push was attempted while the queue was full.

## Operation
- Edge detection uses registered copies last_w and last_sel.
  - push_evt = W3A08n & ~last_w.
  - rise_sel = sel_n & ~last_sel.
  - Both copies reset to 1.
- Push, when not full: writes mem[wr_ptr] = DB_in, increments wr_ptr, increments count.
- Push when full: the data is dropped, pointers and count are unchanged, ovf is set to 1. ovf is cleared only by reset.
- Pop = rise_sel while the state is READ. A pop increments rd_ptr and decrements count.
- rise_sel in any other state is ignored.
- Push and pop on the same edge: both pointers advance and count is unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- cmd_q register behaviour:
  - Loads mem[rd_ptr] every cycle while count != 0.
  - Holds its last value while empty. A spurious read of an empty queue therefore returns the stale byte, as a latch would.
- FSM states: IDLE, PEND, READ, GAP.
  - IDLE: irq_n = 1. Moves to PEND when count != 0.
  - PEND: irq_n = 0. Moves to READ when sel_n is sampled low.
  - READ: irq_n = 1, so selection clears the IRQ as on the PCB. Moves to GAP on rise_sel, which also pops.
  - GAP: irq_n = 1. A counter loads HOLD-1 on entry and decrements each cycle. At 0, moves to PEND if count != 0, otherwise to IDLE.
- irq_n is a registered output decoded from the next state.
- Reset values (asynchronous):
  - Pointers 0, count 0, state IDLE.
  - irq_n 1, cmd_q {DW{1'b1}}, ovf 0.
  - empty 1, full 0.
  - Memory contents are don't-care.

## Timing
- Let E0 be the clk edge at which W3A08n is sampled 1 with last_w = 0.
  - At E0: write into mem and count increment.
  - At E0+1: cmd_q is valid and the FSM goes IDLE->PEND, so irq_n falls.
  - Push-to-IRQ latency is 1 cycle after the edge. cmd_q is never stale when irq_n is low.
- Let S0 be the first edge sampling sel_n = 0 in PEND. irq_n rises at S0 (PEND->READ).
- Let P0 be the rise_sel edge. At P0: pop and READ->GAP. cmd_q shows the next head at P0+1.
- Minimum irq_n high time between commands is HOLD+1 cycles (READ exit through GAP).
- Reset in mid-operation (any state, any count) returns everything to reset values asynchronously. The first push after RSTn deasserts behaves as from an empty queue.
- If sel_n is held low through reset release, last_sel = 1 suppresses a false rise_sel until sel_n goes high again.

## Structure
- Package xs_snd_pkg holds:
  - typedef enum logic [1:0] {IDLE, PEND, READ, GAP} sndq_state_t.
  - Default constants SNDQ_DEPTH = 8, SNDQ_HOLD = 16.
- Sub-module xs_sndcmd_ram: DEPTH x DW register array with one synchronous write port and an asynchronous read port.
- Pointers, count, flags, edge detection and the FSM stay in the top module.

## Test plan
- Reset, then push 0x8A: irq_n low exactly 1 cycle after E0, cmd_q = 0x8A, count = 1. After a sel_n low/high pulse: count = 0, irq_n stays high through GAP, state IDLE.
- Push 0x01, 0x0F, 0x09 back to back: three separate irq_n low pulses, each separated by ≥ HOLD+1 high cycles. Reads return 0x01, 0x0F, 0x09 in order.
- Push 9 bytes with DEPTH = 8: full = 1 after the 8th push, ovf = 1 after the 9th, 9th byte discarded, the 8 reads return bytes 1-8.
- Push on the same clk edge as rise_sel with count = 3: count stays 3, both pointers advance. Order is preserved across the wr_ptr 7->0 wrap.
- sel_n pulse while IDLE: count unchanged, cmd_q holds previous byte, irq_n stays 1.
- Assert RSTn with count = 5 and state PEND: irq_n = 1, count = 0, cmd_q = 0xFF, ovf = 0 immediately. The next push produces a normal single IRQ.
